tick_time_counter: RTL and testbench
====================================

// Module: tick_time_counter
// PURPOSE
//  Downstream consumer of the 1-second divider tick. Keeps an HH:MM:SS time in BCD.
//  Runs, pauses and clears under user control, and drives the six active-low HEX displays.
//  Sits between the clock divider (tick) and the HEX0..HEX5 pins in the DE1_SoC top level.
// PARAMETERS
//  HOUR_WRAP  24  hour count wraps to 00 after HOUR_WRAP-1; legal range 1..99
// PORTS
//  clk         in   1   system clock (CLOCK_50 domain); single clock, all logic posedge
//  reset       in   1   synchronous, active-high; sampled on posedge clk only
//  tick        in   1   one-cycle pulse, one per second, from the divider
//  start_stop  in   1   active-high level (top level inverts KEY); debounced upstream
//  clear       in   1   active-high level; debounced upstream
//  hex0..hex5  out  7   active-low segments {g..a}; hex0=sec units .. hex5=hour tens
//  bcd_time    out  24  {hr_t,hr_u,min_t,min_u,sec_t,sec_u}, 4 bits each
//  running     out  1   1 while state==RUN
//  paused      out  1   1 while state==PAUSE
//  rollover    out  1   one-cycle pulse on wrap (HOUR_WRAP-1):59:59 -> 00:00:00
// BEHAVIOUR
//  Reset: state IDLE, bcd_time=0, running=0, paused=0, rollover=0.
//   Edge-detect registers are cleared; hex0..hex5 all show 7'b1000000 ("0").
//  Edge detect: ss_q<=start_stop and clr_q<=clear each cycle.
//   ss_pulse=start_stop&~ss_q and clr_pulse=clear&~clr_q; they act at the same edge.
//   A held level produces exactly one pulse.
//  FSM (IDLE, RUN, PAUSE):
//   IDLE  --ss_pulse--> RUN;  RUN --ss_pulse--> PAUSE;  PAUSE --ss_pulse--> RUN
//   any state --clr_pulse--> IDLE, with bcd_time<=0
//  Priority within one cycle: reset > clr_pulse > ss_pulse/tick.
//  Counting: bcd_time advances by 1 s at the edge where tick==1 and the current state is RUN.
//   tick together with ss_pulse while in RUN: the tick counts, then the state goes to PAUSE.
//   tick together with ss_pulse while in PAUSE or IDLE: the tick is ignored.
//   tick together with clr_pulse: the tick is ignored and the result is 0.
//  BCD carry chain, combinational ripple, all digits updated at one edge:
//   sec_u 9->0 carries into sec_t; sec_t 5->0 carries into min_u;
//   min_u 9->0 carries into min_t; min_t 5->0 carries into the hours.
//   Hours count 00..HOUR_WRAP-1 in BCD (units 9->0 carries into tens), then wrap to 00.
//   On that wrap rollover=1 for exactly the next cycle.
//  Latency: bcd_time and running/paused are registered and change 1 edge after the qualifying input.
//   hex* are combinational decodes of bcd_time, with no extra cycle.
//  Digits never hold non-BCD values. Decode of 10..15 is defined as blank (7'b1111111) for robustness.
//  reset asserted mid-count restores the reset state at that edge; no partial update.
// STRUCTURE
//  Shared package/include: FSM state encodings (2-bit) and the SEG_0..SEG_9 and SEG_BLANK constants.
//  Sub-module seg7_bcd_decode (4-bit BCD in, 7-bit active-low out), instantiated 6x.
//  Top body holds: edge detectors, FSM, BCD counter chain, rollover register.
// TESTING
//  1 reset, then 3 ticks in IDLE -> bcd_time=24'h000000, hex0=7'b1000000, running=0.
//  2 start_stop high held 10 cycles, then 12 ticks -> one transition to RUN only.
//     Expect bcd_time=24'h000012, hex1=7'b1111001, hex0=7'b0100100.
//  3 preload via 86399 ticks in RUN -> 24'h235959.
//     Next tick -> 24'h000000 and rollover high for exactly 1 cycle.
//     With HOUR_WRAP=12: 11:59:59 -> 00:00:00.
//  4 RUN at 00:00:09, then tick and ss_pulse in the same cycle -> 00:00:10 and PAUSE (paused=1).
//     5 further ticks -> bcd_time unchanged.
//  5 PAUSE at 00:01:00, then clear and tick in the same cycle -> IDLE, bcd_time=0, rollover=0.
//  6 RUN at 00:59:59, then tick with reset=1 -> all outputs at reset values the next cycle.

Source files
------------

// File: rtl/tick_time_counter_pkg.sv
// Shared definitions for the HH:MM:SS tick counter.
//   - state_e     : 2-bit encoding of the IDLE / RUN / PAUSE control states
//   - SEG_*       : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - digit_inc() : one BCD digit increment with carry-out
package tick_time_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Increment one BCD digit that counts 0..last; returns {carry_out, next_digit}.
  function automatic logic [4:0] digit_inc(input logic [3:0] d, input logic [3:0] last);
    if (d == last) digit_inc = {1'b1, 4'd0};
    else           digit_inc = {1'b0, d + 4'd1};
  endfunction

endpackage

// File: rtl/tick_time_counter_seg7.sv
// seg7_bcd_decode: combinational BCD digit to active-low 7-segment decoder.
//   bcd_i [3:0] : BCD digit; codes 10..15 decode to a blank display
//   seg_o [6:0] : active-low segments {g,f,e,d,c,b,a}
module seg7_bcd_decode
  import tick_time_counter_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_time_counter.sv
// tick_time_counter: HH:MM:SS BCD time keeper driven by a 1 Hz tick.
//   clk        : system clock, all logic on posedge
//   reset      : synchronous, active-high
//   tick       : one-cycle pulse per second
//   start_stop : level; rising edge toggles IDLE->RUN, RUN<->PAUSE
//   clear      : level; rising edge returns to IDLE and zeroes the time
//   hex0..hex5 : active-low segments, hex0 = seconds units .. hex5 = hour tens
//   bcd_time   : {hr_t, hr_u, min_t, min_u, sec_t, sec_u}
//   running    : high in RUN
//   paused     : high in PAUSE
//   rollover   : one-cycle pulse after the (HOUR_WRAP-1):59:59 -> 00:00:00 wrap
module tick_time_counter
  import tick_time_counter_pkg::*;
#(
  parameter int HOUR_WRAP = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start_stop,
  input  logic        clear,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic [23:0] bcd_time,
  output logic        running,
  output logic        paused,
  output logic        rollover
);

  // Last legal hour split into BCD tens/units, compared against to detect the wrap.
  localparam logic [3:0] HW_T = 4'((HOUR_WRAP - 1) / 10);
  localparam logic [3:0] HW_U = 4'((HOUR_WRAP - 1) % 10);

  logic        ss_q, clr_q;
  logic        ss_pulse, clr_pulse;
  state_e      state_q, state_d;
  logic [23:0] time_q, time_d;
  logic        rollover_q;
  logic        wrap;
  logic        count_en;
  logic [6:0]  hex_w [6];

  // ---- edge detectors ----
  assign ss_pulse  = start_stop & ~ss_q;
  assign clr_pulse = clear & ~clr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ss_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      ss_q  <= start_stop;
      clr_q <= clear;
    end
  end

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    if (clr_pulse) begin
      state_d = ST_IDLE;
    end else if (ss_pulse) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    running = (state_q == ST_RUN);
    paused  = (state_q == ST_PAUSE);
  end

  // A tick counts only in RUN, using the state before any same-edge start_stop
  // transition; a simultaneous clear wins and the tick is dropped.
  assign count_en = tick & (state_q == ST_RUN) & ~clr_pulse;

  // ---- BCD ripple carry chain ----
  always_comb begin
    logic [4:0] r;
    logic       c;
    time_d = time_q;
    wrap   = 1'b0;
    r      = '0;
    c      = 1'b0;
    if (clr_pulse) begin
      time_d = '0;
    end else if (count_en) begin
      r = digit_inc(time_q[3:0], 4'd9);
      time_d[3:0] = r[3:0];
      c = r[4];
      if (c) begin
        r = digit_inc(time_q[7:4], 4'd5);
        time_d[7:4] = r[3:0];
        c = r[4];
      end
      if (c) begin
        r = digit_inc(time_q[11:8], 4'd9);
        time_d[11:8] = r[3:0];
        c = r[4];
      end
      if (c) begin
        r = digit_inc(time_q[15:12], 4'd5);
        time_d[15:12] = r[3:0];
        c = r[4];
      end
      if (c) begin
        if (time_q[23:20] == HW_T && time_q[19:16] == HW_U) begin
          time_d[23:16] = 8'h00;
          wrap          = 1'b1;
        end else begin
          r = digit_inc(time_q[19:16], 4'd9);
          time_d[19:16] = r[3:0];
          if (r[4]) time_d[23:20] = time_q[23:20] + 4'd1;
        end
      end
    end
  end

  // ---- time and rollover registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      time_q     <= '0;
      rollover_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      rollover_q <= wrap;
    end
  end

  assign bcd_time = time_q;
  assign rollover = rollover_q;

  // ---- display decode, combinational from the registered time ----
  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg7_bcd_decode u_dec (
      .bcd_i (time_q[4*g +: 4]),
      .seg_o (hex_w[g])
    );
  end

  assign hex0 = hex_w[0];
  assign hex1 = hex_w[1];
  assign hex2 = hex_w[2];
  assign hex3 = hex_w[3];
  assign hex4 = hex_w[4];
  assign hex5 = hex_w[5];

endmodule

// File: tb/tb_tick_time_counter.sv
// Bench for tick_time_counter: two instances (HOUR_WRAP 24 and 12) share one
// stimulus stream and are compared against an integer-seconds reference model.
module tb_tick_time_counter;

  logic clk;
  logic rst_r, tick_r, ss_r, clr_r;

  logic [6:0]  hx   [2][6];
  logic [23:0] bcd_o[2];
  logic        run_o[2], pau_o[2], rol_o[2];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tick_time_counter #(.HOUR_WRAP(24)) dut24 (
    .clk(clk), .reset(rst_r), .tick(tick_r), .start_stop(ss_r), .clear(clr_r),
    .hex0(hx[0][0]), .hex1(hx[0][1]), .hex2(hx[0][2]),
    .hex3(hx[0][3]), .hex4(hx[0][4]), .hex5(hx[0][5]),
    .bcd_time(bcd_o[0]), .running(run_o[0]), .paused(pau_o[0]), .rollover(rol_o[0])
  );

  tick_time_counter #(.HOUR_WRAP(12)) dut12 (
    .clk(clk), .reset(rst_r), .tick(tick_r), .start_stop(ss_r), .clear(clr_r),
    .hex0(hx[1][0]), .hex1(hx[1][1]), .hex2(hx[1][2]),
    .hex3(hx[1][3]), .hex4(hx[1][4]), .hex5(hx[1][5]),
    .bcd_time(bcd_o[1]), .running(run_o[1]), .paused(pau_o[1]), .rollover(rol_o[1])
  );

  // ---------------- reference model ----------------
  // Time kept as plain elapsed seconds modulo HOUR_WRAP*3600; state as 0/1/2.
  int m_sec  [2];
  bit m_roll [2];
  int m_state;             // 0 idle, 1 run, 2 pause
  bit m_pss, m_pclr;
  int wrapv  [2] = '{24, 12};

  task automatic model_step(input bit r, input bit t, input bit s, input bit c);
    bit ssp, clp;
    if (r) begin
      m_state = 0; m_pss = 0; m_pclr = 0;
      for (int k = 0; k < 2; k++) begin m_sec[k] = 0; m_roll[k] = 0; end
    end else begin
      ssp = s && !m_pss;
      clp = c && !m_pclr;
      for (int k = 0; k < 2; k++) m_roll[k] = 0;
      if (clp) begin
        m_state = 0;
        for (int k = 0; k < 2; k++) m_sec[k] = 0;
      end else begin
        if (t && m_state == 1) begin
          for (int k = 0; k < 2; k++) begin
            m_sec[k] = m_sec[k] + 1;
            if (m_sec[k] == wrapv[k] * 3600) begin
              m_sec[k]  = 0;
              m_roll[k] = 1;
            end
          end
        end
        if (ssp) m_state = (m_state == 1) ? 2 : 1;
      end
      m_pss  = s;
      m_pclr = c;
    end
  endtask

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, x;
    h = s / 3600; m = (s / 60) % 60; x = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;  4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;  4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;  4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;  4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;  4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [41:0] hex_exp(input logic [23:0] b);
    return {seg(b[23:20]), seg(b[19:16]), seg(b[15:12]), seg(b[11:8]), seg(b[7:4]), seg(b[3:0])};
  endfunction

  function automatic logic [41:0] hex_act(input int k);
    return {hx[k][5], hx[k][4], hx[k][3], hx[k][2], hx[k][1], hx[k][0]};
  endfunction

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("model_bcd[%0d]", k), 48'(bcd_o[k]), 48'(to_bcd(m_sec[k])));
      chk($sformatf("model_hex[%0d]", k), 48'(hex_act(k)), 48'(hex_exp(to_bcd(m_sec[k]))));
      chk($sformatf("model_running[%0d]", k), 48'(run_o[k]), 48'(m_state == 1));
      chk($sformatf("model_paused[%0d]", k), 48'(pau_o[k]), 48'(m_state == 2));
      chk($sformatf("model_rollover[%0d]", k), 48'(rol_o[k]), 48'(m_roll[k]));
    end
  endtask

  // Drive one clock cycle: inputs applied now, DUT and model advance on the edge,
  // outputs sampled 1 time unit later.
  task automatic cycle(input bit r, input bit t, input bit s, input bit c);
    rst_r = r; tick_r = t; ss_r = s; clr_r = c;
    @(posedge clk);
    model_step(r, t, s, c);
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          rep;
    bit          r, t, s, c;
    logic [23:0] bcd;
    bit          run, pau, roll;
  } vec_t;

  vec_t tbl[16];

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      for (int j = 0; j < tbl[i].rep; j++) cycle(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].c);
      chk($sformatf("row%0d_bcd", i),      48'(bcd_o[0]), 48'(tbl[i].bcd));
      chk($sformatf("row%0d_running", i),  48'(run_o[0]), 48'(tbl[i].run));
      chk($sformatf("row%0d_paused", i),   48'(pau_o[0]), 48'(tbl[i].pau));
      chk($sformatf("row%0d_rollover", i), 48'(rol_o[0]), 48'(tbl[i].roll));
    end
  endtask

  initial begin
    bit ss_lvl;
    rst_r = 1'b0; tick_r = 1'b0; ss_r = 1'b0; clr_r = 1'b0;

    //            rep   r  t  s  c  bcd        run pau roll
    tbl[0]  = '{1,    1, 0, 0, 0, 24'h000000, 0, 0, 0};  // reset
    tbl[1]  = '{3,    0, 1, 0, 0, 24'h000000, 0, 0, 0};  // ticks in IDLE
    tbl[2]  = '{10,   0, 0, 1, 0, 24'h000000, 1, 0, 0};  // held start_stop
    tbl[3]  = '{12,   0, 1, 0, 0, 24'h000012, 1, 0, 0};  // 12 ticks
    tbl[4]  = '{1,    0, 0, 0, 1, 24'h000000, 0, 0, 0};  // clear
    tbl[5]  = '{1,    0, 0, 1, 0, 24'h000000, 1, 0, 0};  // start
    tbl[6]  = '{9,    0, 1, 0, 0, 24'h000009, 1, 0, 0};
    tbl[7]  = '{1,    0, 1, 1, 0, 24'h000010, 0, 1, 0};  // tick + start_stop in RUN
    tbl[8]  = '{5,    0, 1, 0, 0, 24'h000010, 0, 1, 0};  // ticks ignored in PAUSE
    tbl[9]  = '{1,    0, 0, 1, 0, 24'h000010, 1, 0, 0};  // resume
    tbl[10] = '{50,   0, 1, 0, 0, 24'h000100, 1, 0, 0};
    tbl[11] = '{1,    0, 0, 1, 0, 24'h000100, 0, 1, 0};  // pause at 00:01:00
    tbl[12] = '{1,    0, 1, 0, 1, 24'h000000, 0, 0, 0};  // clear + tick
    tbl[13] = '{1,    0, 0, 1, 0, 24'h000000, 1, 0, 0};  // start
    tbl[14] = '{3599, 0, 1, 0, 0, 24'h005959, 1, 0, 0};
    tbl[15] = '{1,    1, 1, 0, 0, 24'h000000, 0, 0, 0};  // reset + tick

    run_rows(0, 1);
    chk("idle_hex0", 48'(hx[0][0]), 48'(7'b1000000));
    run_rows(2, 3);
    chk("run12_hex1", 48'(hx[0][1]), 48'(7'b1111001));
    chk("run12_hex0", 48'(hx[0][0]), 48'(7'b0100100));
    run_rows(4, 15);
    chk("reset_hex_all", 48'(hex_act(0)), 48'({6{7'b1000000}}));

    // ---------------- randomized phase ----------------
    ss_lvl = 1'b0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 7) == 0) ss_lvl = ~ss_lvl;
      cycle($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)), ss_lvl,
            $urandom_range(0, 39) == 0);
    end

    // ---------------- full-day rollover ----------------
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    for (int i = 1; i <= 86399; i++) begin
      cycle(0, 1, 0, 0);
      if (i == 43199) chk("w12_pre_wrap", 48'(bcd_o[1]), 48'(24'h115959));
      if (i == 43200) begin
        chk("w12_wrap_bcd", 48'(bcd_o[1]), 48'(24'h000000));
        chk("w12_wrap_roll", 48'(rol_o[1]), 48'(1'b1));
      end
      if (i == 43201) chk("w12_roll_once", 48'(rol_o[1]), 48'(1'b0));
    end
    chk("w24_pre_wrap", 48'(bcd_o[0]), 48'(24'h235959));
    chk("w24_pre_roll", 48'(rol_o[0]), 48'(1'b0));
    cycle(0, 1, 0, 0);
    chk("w24_wrap_bcd", 48'(bcd_o[0]), 48'(24'h000000));
    chk("w24_wrap_roll", 48'(rol_o[0]), 48'(1'b1));
    cycle(0, 0, 0, 0);
    chk("w24_roll_once", 48'(rol_o[0]), 48'(1'b0));
    chk("w24_after_bcd", 48'(bcd_o[0]), 48'(24'h000000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
